// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
// The BCD increment helper keeps every digit legal BCD through the carry chain.
package stop_watch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2
   } sw_state_e;

   localparam int unsigned TIME_W     = 24;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = TIME_W / DIGIT_W;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX_UNITS = 4'd9;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX_TENS  = 4'd5;
   localparam logic [TIME_W-1:0]  ZERO_TIME       = '0;

   // Digit order from LSB: C0, C1, S0, S1, M0, M1; S1 and M1 roll over at 5.
   function automatic logic [TIME_W-1:0] bcd_time_inc(input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0]  r;
      logic               carry;
      logic [DIGIT_W-1:0] d;
      logic [DIGIT_W-1:0] dmax;
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d    = t[i*DIGIT_W +: DIGIT_W];
         dmax = (i == 3 || i == 5) ? DIGIT_MAX_TENS : DIGIT_MAX_UNITS;
         if (carry) begin
            if (d == dmax) begin
               d = '0;
            end else begin
               d     = d + 1'b1;
               carry = 1'b0;
            end
         end
         r[i*DIGIT_W +: DIGIT_W] = d;
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_falling_edge.sv
// Active-low push-button press detector: one sync flop plus a delay flop,
// producing a single-cycle pulse on each high-to-low transition.
module btn_falling_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_n,
   output logic o_press
);

   logic r_sync;
   logic r_dly;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= 1'b1;
         r_dly  <= 1'b1;
      end else begin
         r_sync <= i_btn_n;
         r_dly  <= r_sync;
      end
   end

   assign o_press = r_dly & ~r_sync;

endmodule

// File: rtl/stop_watch.sv
// Centisecond stopwatch with start/pause, stop/clear and lap record buttons.
// Define STOPWATCH_RECORD_EN to build the lap record register.
module stop_watch
   import stop_watch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 500000
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              fStart,
   input  logic              fStop,
   input  logic              fRecord,
   output logic [TIME_W-1:0] oTime,
   output logic [TIME_W-1:0] oRecord
);

   localparam int unsigned PRESC_W = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic              w_start_press;
   logic              w_stop_press;
   logic              w_record_press;
   sw_state_e         r_state;
   sw_state_e         w_state_nxt;
   logic [PRESC_W-1:0] r_presc;
   logic [TIME_W-1:0] r_time;
   logic [TIME_W-1:0] w_time_inc;
   logic              w_tick;

   btn_falling_edge u_btn_start (
      .i_clk   (Clk),
      .i_rst   (Rst),
      .i_btn_n (fStart),
      .o_press (w_start_press)
   );

   btn_falling_edge u_btn_stop (
      .i_clk   (Clk),
      .i_rst   (Rst),
      .i_btn_n (fStop),
      .o_press (w_stop_press)
   );

   btn_falling_edge u_btn_record (
      .i_clk   (Clk),
      .i_rst   (Rst),
      .i_btn_n (fRecord),
      .o_press (w_record_press)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Stop overrides start in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      if (w_stop_press) begin
         w_state_nxt = StIdle;
      end else if (w_start_press) begin
         unique case (r_state)
            StIdle:  w_state_nxt = StRun;
            StRun:   w_state_nxt = StPause;
            StPause: w_state_nxt = StRun;
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_comb begin
      w_tick     = (r_state == StRun) && (r_presc == PRESC_LAST);
      w_time_inc = bcd_time_inc(r_time);
   end

   always_ff @(posedge Clk) begin
      if (Rst || w_stop_press || r_state == StIdle) begin
         r_presc <= '0;
      end else if (r_state == StRun) begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst || w_stop_press) begin
         r_time <= ZERO_TIME;
      end else if (w_tick) begin
         r_time <= w_time_inc;
      end
   end

   assign oTime = r_time;

`ifdef STOPWATCH_RECORD_EN
   logic [TIME_W-1:0] r_record;

   // Captures the pre-increment time when a tick lands in the same cycle.
   always_ff @(posedge Clk) begin
      if (Rst || w_stop_press) begin
         r_record <= ZERO_TIME;
      end else if (w_record_press && r_state != StIdle) begin
         r_record <= r_time;
      end
   end

   assign oRecord = r_record;
`else
   logic w_unused_record;
   assign w_unused_record = w_record_press;
   assign oRecord         = ZERO_TIME;
`endif

endmodule

// File: tb/tb_stop_watch.sv
// Directed self-checking bench for stop_watch with TICK_DIV=2 (one tick per two cycles).
module tb_stop_watch;

   logic        Clk;
   logic        Rst;
   logic        fStart;
   logic        fStop;
   logic        fRecord;
   logic [23:0] oTime;
   logic [23:0] oRecord;

   int n_checks;
   int n_pass;

`ifdef STOPWATCH_RECORD_EN
   localparam bit REC_EN = 1'b1;
`else
   localparam bit REC_EN = 1'b0;
`endif

   stop_watch #(
      .TICK_DIV (2)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .fStart  (fStart),
      .fStop   (fStop),
      .fRecord (fRecord),
      .oTime   (oTime),
      .oRecord (oRecord)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [23:0] exp_bcd(input int cs);
      int m;
      int s;
      int c;
      m = (cs % 360000) / 6000;
      s = (cs / 100) % 60;
      c = cs % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   function automatic logic [23:0] exp_rec(input logic [23:0] v);
      return REC_EN ? v : 24'h000000;
   endfunction

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %06h expected %06h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Called at a negedge; buttons are low across exactly one rising edge.
   task automatic pulse(input logic s, input logic p, input logic r);
      fStart  = ~s;
      fStop   = ~p;
      fRecord = ~r;
      @(negedge Clk);
      fStart  = 1'b1;
      fStop   = 1'b1;
      fRecord = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      Rst      = 1'b1;
      fStart   = 1'b0;
      fStop    = 1'b1;
      fRecord  = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_time", oTime, 24'h000000);
      check("rst_rec", oRecord, 24'h000000);
      fStart  = 1'b1;
      fRecord = 1'b1;
      Rst     = 1'b0;
      repeat (10) @(negedge Clk);
      check("idle_after_rst", oTime, 24'h000000);

      pulse(1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge Clk);
      check("idle_rec_ignored", oRecord, 24'h000000);
      check("idle_time", oTime, 24'h000000);

      pulse(1'b1, 1'b0, 1'b0);
      repeat (21) @(negedge Clk);
      check("run_10", oTime, 24'h000010);
      repeat (30) @(negedge Clk);
      check("run_25", oTime, 24'h000025);

      pulse(1'b0, 1'b0, 1'b1);
      repeat (1) @(negedge Clk);
      check("rec_run", oRecord, exp_rec(24'h000025));
      check("rec_time_keeps", oTime, 24'h000026);
      repeat (348) @(negedge Clk);
      check("run_200", oTime, 24'h000200);
      check("rec_hold", oRecord, exp_rec(24'h000025));

      pulse(1'b1, 1'b0, 1'b0);
      repeat (1) @(negedge Clk);
      check("pause_enter", oTime, 24'h000201);
      repeat (100) @(negedge Clk);
      check("pause_frozen", oTime, 24'h000201);
      pulse(1'b0, 1'b0, 1'b1);
      repeat (1) @(negedge Clk);
      check("rec_pause", oRecord, exp_rec(24'h000201));
      pulse(1'b1, 1'b0, 1'b0);
      repeat (21) @(negedge Clk);
      check("resume", oTime, 24'h000211);

      pulse(1'b1, 1'b1, 1'b0);
      repeat (1) @(negedge Clk);
      check("stop_time", oTime, 24'h000000);
      check("stop_rec", oRecord, 24'h000000);
      repeat (10) @(negedge Clk);
      check("stop_idle", oTime, 24'h000000);

      pulse(1'b1, 1'b0, 1'b0);
      repeat (11) @(negedge Clk);
      check("restart_5", oTime, exp_bcd(5));
      repeat (2 * (5998 - 5)) @(negedge Clk);
      check("run_5998", oTime, 24'h005998);
      repeat (2) @(negedge Clk);
      check("run_5999", oTime, 24'h005999);
      repeat (2) @(negedge Clk);
      check("min_carry", oTime, 24'h010000);

      pulse(1'b1, 1'b0, 1'b0);
      repeat (1) @(negedge Clk);
      check("pause_2", oTime, 24'h010001);
      force dut.r_time = 24'h595998;
      @(negedge Clk);
      release dut.r_time;
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge Clk);
      check("run_595999", oTime, 24'h595999);
      repeat (2) @(negedge Clk);
      check("hour_wrap", oTime, 24'h000000);
      repeat (2) @(negedge Clk);
      check("after_wrap", oTime, exp_bcd(360001));

      fStart = 1'b0;
      Rst    = 1'b1;
      @(negedge Clk);
      check("midrun_rst", oTime, 24'h000000);
      check("midrun_rst_rec", oRecord, 24'h000000);
      fStart = 1'b1;
      Rst    = 1'b0;
      repeat (10) @(negedge Clk);
      check("post_rst_idle", oTime, 24'h000000);

      // A held button must start once, not toggle run/pause every cycle.
      fStart = 1'b0;
      repeat (5) @(negedge Clk);
      fStart = 1'b1;
      repeat (16) @(negedge Clk);
      check("held_start", oTime, exp_bcd(9));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stop_watch.md
# stop_watch

Centisecond stopwatch with start/pause, lap record and stop/clear controls driven by three active-low push-button inputs. Runs from the single system clock, derives a 100 Hz tick with a prescaler, and presents the running time and the last recorded lap as packed BCD MM:SS:CC words. It sits between the board button inputs and the display/readout logic.

## Interface
- TICK_DIV, 500000: clock cycles per 1/100 s tick (50 MHz clock); must be ≥ 2.
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  synchronous reset, active-high.
- fStart  in  1  start/pause button, active-low.
- fStop  in  1  stop/clear button, active-low.
- fRecord  in  1  lap-record button, active-low.
- oTime  out  24  running time, BCD {M1,M0,S1,S0,C1,C0}, 4 bits per digit.
- oRecord  out  24  last recorded lap, same format.

## Operation
- Each button passes through one sync flop plus a delay flop; a press is a 1-cycle pulse on the high→low transition. Holding a button low produces one press only.
- States: IDLE (stopped, time zero), RUN, PAUSE.
- fStart press: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
- fStop press (any state): →IDLE; oTime, prescaler and oRecord cleared to 0.
- fRecord press in RUN or PAUSE: oRecord ← current oTime (value before this cycle's increment). Ignored in IDLE.
- Priority in the same cycle: fStop overrides fStart and fRecord; fStart and fRecord otherwise both take effect.
- Prescaler counts 0..TICK_DIV-1 only in RUN; a tick occurs on the wrap. It holds in PAUSE and clears in IDLE.
- On a tick: C0 +1; 9→0 carries to C1; C1 9→0 carries to S0; S0 9→0 to S1; S1 5→0 to M0; M0 9→0 to M1; M1 5→0. 59:59.99 wraps to 00:00.00 and keeps running.
- All digits stay legal BCD; no binary intermediate.

## Timing
- Reset: state IDLE, oTime=0x000000, oRecord=0x000000, prescaler 0, sync flops set to 1 (released). This holds while Rst=1.
- Button latency: input low before edge N → pulse between N and N+1 → action visible after edge N+1.
- After entering RUN at edge K, the first tick increments oTime at edge K+TICK_DIV.
- Outputs are registered, with no combinational path from inputs.
- Reset mid-run takes effect at the next edge regardless of button state.

## Configuration
- STOPWATCH_RECORD_EN defined: lap record register and fRecord logic present as above.
- Not defined: fRecord ignored, oRecord tied to 0x000000, no record register synthesized.

## Structure
- Package stop_watch_pkg: state enum (IDLE/RUN/PAUSE), TIME_W=24, DIGIT_W=4, digit max constants (9, 5), zero-time constant.
- One sub-module btn_falling_edge (sync flop, delay flop, active-low press pulse), instantiated three times.

## Test plan
- Reset: Rst=1 for 2 cycles → oTime=0, oRecord=0, state IDLE. Buttons pulsed low during reset are ignored.
- Start/run with TICK_DIV=2: one-cycle fStart low pulse, then 20 cycles → oTime=0x000010 (±1 tick at boundary); 200 ticks → 0x000200.
- Record: in RUN at oTime=0x000025, fRecord pulse → oRecord=0x000025 while oTime keeps counting. A record in IDLE leaves oRecord=0.
- Pause/resume: second fStart pulse → oTime frozen for 100 cycles; a third pulse resumes from the frozen value.
- Stop: fStop pulse in RUN with fStart pulsed the same cycle → oTime=0, oRecord=0, state IDLE.
- Rollover: preload or run to 0x005999 → next tick 0x010000; at 0x595999 → next tick 0x000000.
